// File: rtl/q_sys_onchip_memory_dp.sv
// q_sys_onchip_memory_dp: true-dual-port Avalon-MM on-chip RAM with per-byte
// even parity, a clear-after-reset sequencer and a fixed-latency
// readdatavalid pipeline on each slave port.
module q_sys_onchip_memory_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 49152,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clken,
  input  logic [ADDR_WIDTH-1:0]     s1_address,
  input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
  input  logic                      s1_chipselect,
  input  logic                      s1_read,
  input  logic                      s1_write,
  input  logic [DATA_WIDTH-1:0]     s1_writedata,
  output logic [DATA_WIDTH-1:0]     s1_readdata,
  output logic                      s1_readdatavalid,
  output logic                      s1_waitrequest,
  output logic                      s1_parity_error,
  input  logic [ADDR_WIDTH-1:0]     s2_address,
  input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [DATA_WIDTH-1:0]     s2_writedata,
  output logic [DATA_WIDTH-1:0]     s2_readdata,
  output logic                      s2_readdatavalid,
  output logic                      s2_waitrequest,
  output logic                      s2_parity_error,
  input  logic                      inject_parity,
  output logic                      clear_busy,
  output logic                      parity_error_sticky
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    CLR_LAST  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;
  // With clearing enabled the sequencer is already armed while reset is held,
  // so the first enabled edge after release writes address 0.
  localparam state_t ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RESET;

  state_t           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic             busy_q;
  logic             clear_busy_q;
  logic             sticky_q;
  logic             wait_all;
  logic             clear_wr;

  // Both ports bundled into two-entry arrays so the per-port logic is generated once.
  logic [ADDR_WIDTH-1:0] p_addr     [2];
  logic [NB-1:0]         p_be       [2];
  logic [DATA_WIDTH-1:0] p_wdata    [2];
  logic                  p_cs       [2];
  logic                  p_rd       [2];
  logic                  p_wr       [2];
  logic [IDX_W-1:0]      p_idx      [2];
  logic                  p_in_range [2];
  logic                  p_wr_acc   [2];
  logic                  p_rd_acc   [2];
  logic [NB-1:0]         p_wpar     [2];
  logic [DATA_WIDTH-1:0] p_rdata    [2];
  logic                  p_rvalid   [2];
  logic                  p_perr     [2];
  logic [8:0]            rd_lane    [2][NB];

  assign p_addr[0]  = s1_address;
  assign p_addr[1]  = s2_address;
  assign p_be[0]    = s1_byteenable;
  assign p_be[1]    = s2_byteenable;
  assign p_wdata[0] = s1_writedata;
  assign p_wdata[1] = s2_writedata;
  assign p_cs[0]    = s1_chipselect;
  assign p_cs[1]    = s2_chipselect;
  assign p_rd[0]    = s1_read;
  assign p_rd[1]    = s2_read;
  assign p_wr[0]    = s1_write;
  assign p_wr[1]    = s2_write;

  assign s1_readdata      = p_rdata[0];
  assign s2_readdata      = p_rdata[1];
  assign s1_readdatavalid = p_rvalid[0];
  assign s2_readdatavalid = p_rvalid[1];
  assign s1_parity_error  = p_perr[0];
  assign s2_parity_error  = p_perr[1];

  // Stall during clear, and whenever the clock enable freezes the block.
  assign wait_all            = busy_q | ~clken;
  assign s1_waitrequest      = wait_all;
  assign s2_waitrequest      = wait_all;
  assign clear_busy          = clear_busy_q;
  assign clear_wr            = clear_busy_q & clken;
  assign parity_error_sticky = sticky_q | p_perr[0] | p_perr[1];

  // Sequencer: optional clear sweep of every word, then normal operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      clr_cnt_q    <= '0;
      busy_q       <= 1'b1;
      clear_busy_q <= (CLEAR_ON_RESET != 0);
    end else if (clken) begin
      case (state_q)
        ST_RESET: begin
          state_q      <= ST_RUN;
          busy_q       <= 1'b0;
          clear_busy_q <= 1'b0;
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q      <= ST_RUN;
            busy_q       <= 1'b0;
            clear_busy_q <= 1'b0;
            clr_cnt_q    <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky parity flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else if (p_perr[0] | p_perr[1]) begin
      sticky_q <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam bit IS_S1 = (gi == 0);

    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_q;
    logic [READ_LATENCY-1:0][NB-1:0]         par_q;
    logic [READ_LATENCY-1:0]                 vld_q;
    logic [DATA_WIDTH-1:0]                   raw_data;
    logic [NB-1:0]                           raw_par;
    logic [NB-1:0]                           wpar;
    logic [NB-1:0]                           lane_bad;

    assign p_idx[gi]      = p_addr[gi][IDX_W-1:0];
    assign p_in_range[gi] = {1'b0, p_addr[gi]} < DEPTH_EXT;
    assign p_wr_acc[gi]   = p_cs[gi] & p_wr[gi] & ~wait_all;
    assign p_rd_acc[gi]   = p_cs[gi] & p_rd[gi] & ~p_wr[gi] & ~wait_all;
    assign p_wpar[gi]     = wpar;

    // Write parity per byte (inverted on s1 when the test hook is set),
    // raw read word assembly and output-side parity recheck.
    always_comb begin
      wpar     = '0;
      raw_data = '0;
      raw_par  = '0;
      lane_bad = '0;
      for (int b = 0; b < NB; b++) begin
        wpar[b]            = (^p_wdata[gi][8*b +: 8]) ^ (inject_parity & IS_S1);
        raw_data[8*b +: 8] = rd_lane[gi][b][7:0];
        raw_par[b]         = rd_lane[gi][b][8];
        lane_bad[b]        = (^data_q[READ_LATENCY-1][8*b +: 8]) ^ par_q[READ_LATENCY-1][b];
      end
    end

    // Read pipeline: stage 0 captures the array (or zero when out of range),
    // later stages shift only on enabled cycles; reset flushes everything.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q  <= '0;
        data_q <= '0;
        par_q  <= '0;
      end else if (clken) begin
        vld_q[0] <= p_rd_acc[gi];
        if (p_rd_acc[gi]) begin
          data_q[0] <= p_in_range[gi] ? raw_data : '0;
          par_q[0]  <= p_in_range[gi] ? raw_par  : '0;
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
          vld_q[k]  <= vld_q[k-1];
          data_q[k] <= data_q[k-1];
          par_q[k]  <= par_q[k-1];
        end
      end
    end

    assign p_rdata[gi]  = data_q[READ_LATENCY-1];
    assign p_rvalid[gi] = vld_q[READ_LATENCY-1] & clken;
    assign p_perr[gi]   = p_rvalid[gi] & (|lane_bad);
  end

  for (genvar bi = 0; bi < NB; bi++) begin : g_lane
    logic [8:0] lane_q  [DEPTH];
    logic [8:0] wr_word [2];
    logic       wr_en   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_acc
      assign wr_word[gi]     = {p_wpar[gi][bi], p_wdata[gi][8*bi +: 8]};
      assign wr_en[gi]       = p_wr_acc[gi] & p_in_range[gi] & p_be[gi][bi];
      assign rd_lane[gi][bi] = lane_q[p_idx[gi]];
    end

    // Byte lane storage {parity, data}; s2 is applied before s1 so s1 wins a shared lane.
    always_ff @(posedge clk) begin
      if (clear_wr) lane_q[clr_cnt_q] <= '0;
      if (wr_en[1]) lane_q[p_idx[1]]  <= wr_word[1];
      if (wr_en[0]) lane_q[p_idx[0]]  <= wr_word[0];
    end
  end

endmodule

// File: tb/tb_q_sys_onchip_memory_dp.sv
// Bench for q_sys_onchip_memory_dp: directed scenarios plus a random phase,
// checked every cycle against a word/byte-level reference memory and a
// queue of expected read returns.
module tb_q_sys_onchip_memory_dp;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int NB    = 4;
  localparam int DEPTH = 64;
  localparam int RL    = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clken;
  logic          inject_parity;
  logic [AW-1:0] s1_address, s2_address;
  logic [NB-1:0] s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [DW-1:0] s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid;
  logic          s1_waitrequest, s2_waitrequest;
  logic          s1_parity_error, s2_parity_error;
  logic          clear_busy, parity_error_sticky;

  always #5 clk = ~clk;

  q_sys_onchip_memory_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s1_parity_error(s1_parity_error),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_writedata(s2_writedata), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .s2_parity_error(s2_parity_error),
    .inject_parity(inject_parity), .clear_busy(clear_busy),
    .parity_error_sticky(parity_error_sticky)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    int            due;
  } rd_t;

  int            errors = 0;
  int            checks = 0;
  rd_t           q1[$];
  rd_t           q2[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [NB-1:0] bad_m [DEPTH];
  logic          sticky_m = 1'b0;
  bit            running = 1'b0;
  int            en_cnt = 0;
  int            nvalid1 = 0;
  int            nvalid2 = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
    s1_address = '0; s2_address = '0;
    s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    inject_parity = 0;
  endtask

  task automatic cmd1(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [NB-1:0] be, input logic [DW-1:0] wd);
    s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
    s1_address = a; s1_byteenable = be; s1_writedata = wd;
  endtask

  task automatic cmd2(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [NB-1:0] be, input logic [DW-1:0] wd);
    s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
    s2_address = a; s2_byteenable = be; s2_writedata = wd;
  endtask

  // Expected return of a read: stored word plus "any lane corrupted", zero when out of range.
  function automatic rd_t make_rd(input logic [AW-1:0] a);
    rd_t r;
    r.due = en_cnt + RL;
    if (a < DEPTH) begin
      r.d  = mem_m[a[5:0]];
      r.pe = |bad_m[a[5:0]];
    end else begin
      r.d  = '0;
      r.pe = 1'b0;
    end
    return r;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [NB-1:0] be,
                             input logic [DW-1:0] wd, input logic inj);
    if (a < DEPTH) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem_m[a[5:0]][8*b +: 8] = wd[8*b +: 8];
          bad_m[a[5:0]][b]        = inj;
        end
      end
    end
  endtask

  // One clock: entered at a falling edge with inputs already applied.
  task automatic step();
    logic exp_v;
    logic pe_now;
    logic acc1, acc2;
    rd_t  r;
    #1;
    pe_now = 1'b0;
    if (!reset_n) begin
      q1.delete(); q2.delete();
      sticky_m = 1'b0;
      running  = 1'b0;
    end
    exp_v = clken && (q1.size() > 0) && (q1[0].due == en_cnt);
    chk("s1_rvalid", 32'(s1_readdatavalid), 32'(exp_v));
    if (s1_readdatavalid === 1'b1) nvalid1++;
    if (exp_v) begin
      r = q1.pop_front();
      chk("s1_rdata", s1_readdata, r.d);
      chk("s1_perr", 32'(s1_parity_error), 32'(r.pe));
      pe_now |= r.pe;
    end else begin
      chk("s1_perr_idle", 32'(s1_parity_error), 32'd0);
    end
    exp_v = clken && (q2.size() > 0) && (q2[0].due == en_cnt);
    chk("s2_rvalid", 32'(s2_readdatavalid), 32'(exp_v));
    if (s2_readdatavalid === 1'b1) nvalid2++;
    if (exp_v) begin
      r = q2.pop_front();
      chk("s2_rdata", s2_readdata, r.d);
      chk("s2_perr", 32'(s2_parity_error), 32'(r.pe));
      pe_now |= r.pe;
    end else begin
      chk("s2_perr_idle", 32'(s2_parity_error), 32'd0);
    end
    sticky_m = sticky_m | pe_now;
    chk("sticky", 32'(parity_error_sticky), 32'(sticky_m));
    chk("s1_wait", 32'(s1_waitrequest), 32'(!running || !clken));
    chk("s2_wait", 32'(s2_waitrequest), 32'(!running || !clken));
    acc1 = running && clken && s1_chipselect && (s1_read || s1_write);
    acc2 = running && clken && s2_chipselect && (s2_read || s2_write);
    if (acc1 && s1_read && !s1_write) q1.push_back(make_rd(s1_address));
    if (acc2 && s2_read && !s2_write) q2.push_back(make_rd(s2_address));
    if (acc2 && s2_write) model_write(s2_address, s2_byteenable, s2_writedata, 1'b0);
    if (acc1 && s1_write) model_write(s1_address, s1_byteenable, s1_writedata, inject_parity);
    if (clken) en_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called right after reset_n is released at a falling edge.
  task automatic wait_clear();
    int n;
    n = 0;
    #1;
    chk("clear_busy_hi", 32'(clear_busy), 32'd1);
    while (s1_waitrequest === 1'b1 && n < 300) begin
      n++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk("clear_len", n, 32'd64);
    chk("clear_busy_lo", 32'(clear_busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      bad_m[i] = '0;
    end
    running = 1'b1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(64, 80));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    int base1, base2;
    reset_n = 1'b0;
    clken   = 1'b1;
    idle();
    @(negedge clk);
    #1;
    chk("rst_s1_rdata", s1_readdata, 32'd0);
    chk("rst_s2_rdata", s2_readdata, 32'd0);
    chk("rst_s1_rvalid", 32'(s1_readdatavalid), 32'd0);
    chk("rst_s1_perr", 32'(s1_parity_error), 32'd0);
    chk("rst_sticky", 32'(parity_error_sticky), 32'd0);
    chk("rst_s1_wait", 32'(s1_waitrequest), 32'd1);
    chk("rst_s2_wait", 32'(s2_waitrequest), 32'd1);
    chk("rst_clear_busy", 32'(clear_busy), 32'd1);
    @(negedge clk);
    repeat (3) step();
    reset_n = 1'b1;
    wait_clear();

    // Whole array reads back as zero on both ports.
    for (int a = 0; a < DEPTH; a++) begin
      cmd1(1, 0, AW'(a), '0, '0);
      cmd2(1, 0, AW'(DEPTH - 1 - a), '0, '0);
      step();
    end
    idle(); repeat (3) step();

    // Partial byte write then read back.
    cmd1(0, 1, 16'd5, 4'b0101, 32'hDEADBEEF); step();
    idle(); cmd1(1, 0, 16'd5, '0, '0); step();
    idle(); repeat (3) step();

    // Same-cycle writes to one address with overlapping lanes.
    cmd1(0, 1, 16'd9, 4'b0011, 32'h11111111);
    cmd2(0, 1, 16'd9, 4'b0110, 32'h22222222);
    step();
    idle(); cmd2(1, 0, 16'd9, '0, '0); step();
    idle(); repeat (3) step();

    // Corrupted parity written by s1, detected on s2.
    cmd1(0, 1, 16'd3, 4'b1111, 32'hA5A5A5A5); inject_parity = 1'b1; step();
    idle(); cmd2(1, 0, 16'd3, '0, '0); step();
    idle(); repeat (4) step();
    chk("sticky_hold", 32'(parity_error_sticky), 32'd1);

    // Distinct data in 0..7, then streaming reads with a 3-cycle freeze.
    for (int a = 0; a < 8; a++) begin
      cmd1(0, 1, AW'(a), 4'b1111, $urandom); step();
    end
    idle();
    base1 = nvalid1; base2 = nvalid2;
    for (int a = 0; a < 8; a++) begin
      cmd1(1, 0, AW'(a), '0, '0);
      cmd2(1, 0, AW'(a), '0, '0);
      if (a == 4) begin
        clken = 1'b0; repeat (3) step(); clken = 1'b1;
      end
      step();
    end
    idle(); repeat (4) step();
    chk("stream_s1_count", nvalid1 - base1, 32'd8);
    chk("stream_s2_count", nvalid2 - base2, 32'd8);

    // Out-of-range read and write.
    cmd1(1, 0, 16'd70, '0, '0);
    cmd2(0, 1, 16'd70, 4'b1111, 32'hFFFFFFFF);
    step();
    idle(); repeat (3) step();

    // Random traffic with occasional freezes, collisions and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      clken = ($urandom_range(0, 9) != 0);
      s1_chipselect = 1'($urandom_range(0, 3) != 0);
      s1_read = 1'($urandom_range(0, 1)); s1_write = 1'($urandom_range(0, 1));
      s1_address = rnd_addr(); s1_byteenable = 4'($urandom); s1_writedata = $urandom;
      s2_chipselect = 1'($urandom_range(0, 3) != 0);
      s2_read = 1'($urandom_range(0, 1)); s2_write = 1'($urandom_range(0, 1));
      s2_address = rnd_addr(); s2_byteenable = 4'($urandom); s2_writedata = $urandom;
      inject_parity = 1'($urandom_range(0, 7) == 0);
      step();
    end
    clken = 1'b1; idle(); repeat (4) step();

    // Reset while reads are in flight: nothing may come out.
    cmd1(1, 0, 16'd1, '0, '0); cmd2(1, 0, 16'd2, '0, '0); step();
    idle(); reset_n = 1'b0; repeat (2) step();
    reset_n = 1'b1;
    // Let the clear reach address 30, then pulse reset again.
    repeat (30) step();
    reset_n = 1'b0; step();
    reset_n = 1'b1;
    wait_clear();

    for (int a = 0; a < 8; a++) begin
      cmd1(1, 0, AW'(a), '0, '0); cmd2(1, 0, AW'(a + 8), '0, '0); step();
    end
    idle();
    for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) step();
    chk("drain_s1", q1.size(), 32'd0);
    chk("drain_s2", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/q_sys_onchip_memory_dp.md
# q_sys_onchip_memory_dp

Parametrised true-dual-port on-chip RAM for the q_sys Qsys fabric, generalising the single-port Avalon-MM memory to configurable width, depth and read latency. Two independent Avalon-MM slaves (s1, s2) share one storage array. Adds byte-parity checking, a clear-on-reset sequencer and an explicit readdatavalid pipeline, so NIOS/TPU masters can detect corrupted words.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8; byte lanes NB = DATA_WIDTH/8.
- ADDR_WIDTH, 16: word address width.
- DEPTH, 49152: number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 2: accept-to-readdatavalid cycles; legal range 1..3.
- CLEAR_ON_RESET, 1: 1 = zero the array after reset, 0 = skip.
- clk  in  1  single clock for everything.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  global clock enable; low freezes all state.
- sN_address  in  ADDR_WIDTH  word address (N = 1, 2).
- sN_byteenable  in  NB  write byte enables.
- sN_chipselect, sN_read, sN_write  in  1  Avalon-MM controls.
- sN_writedata  in  DATA_WIDTH  write data.
- sN_readdata  out  DATA_WIDTH  read data.
- sN_readdatavalid  out  1  one-cycle pulse qualifying sN_readdata.
- sN_waitrequest  out  1  command stall.
- sN_parity_error  out  1  pulse with readdatavalid when the returned word fails parity.
- inject_parity  in  1  test hook: inverts the stored parity of s1 writes.
- clear_busy  out  1  high while the clear sequencer runs.
- parity_error_sticky  out  1  set on any parity_error; cleared only by reset.

## Operation
- Storage: DEPTH words plus NB even-parity bits per word (parity bit = XOR of its byte).
- FSM states: RESET → CLEAR (only if CLEAR_ON_RESET=1) → RUN. Otherwise RESET → RUN.
- CLEAR: counter walks 0..DEPTH-1, one word per enabled cycle, writing data 0 and parity 0. Move to RUN after address DEPTH-1.
- During CLEAR, clear_busy=1 and both waitrequests are 1. In RUN, waitrequest = ~clken.
- A command is accepted when chipselect & (read | write) & ~waitrequest.
- Write: bytes with byteenable=1 are updated together with their parity bits. inject_parity=1 on an s1 write stores inverted parity for the enabled bytes.
- Read: data and parity are captured and enter a READ_LATENCY-deep valid/data pipeline.
  - Parity is recomputed at the output. Any lane mismatch raises sN_parity_error with readdatavalid.
- read and write asserted together: treated as a write only; no readdatavalid.
- Address ≥ DEPTH: writes are dropped. Reads return 0 with readdatavalid=1 and parity_error=0.
- Same-address writes from both ports in one cycle, per byte:
  - s1 wins on lanes both ports enable.
  - s2 lanes enabled only by s2 are written.
- Read of an address being written in the same cycle (either port) returns the old data (read-first).
- clken=0 holds the pipeline, FSM and counter. Outputs keep their values; readdatavalid is held at 0 while frozen.

## Timing
- Reset values:
  - readdata = 0, readdatavalid = 0, parity_error = 0, parity_error_sticky = 0.
  - waitrequest = 1 and clear_busy = CLEAR_ON_RESET.
  - If CLEAR_ON_RESET=0, waitrequest drops to 0 on the first clk after reset_n deasserts.
- Clear duration: exactly DEPTH enabled cycles. waitrequest falls the cycle after the final clear write.
- Read accepted at cycle T → readdatavalid at T+READ_LATENCY (enabled cycles). Throughput is one read per port per cycle.
- Write accepted at T is visible to a read accepted at T+1 on either port.
- reset_n asserted mid-clear or mid-read: the pipeline is flushed with no readdatavalid emitted, and the clear restarts from address 0.
- parity_error_sticky rises in the same cycle as the first parity_error.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=64 → waitrequest high for 64 cycles; afterwards, reads of addresses 0..63 return 0 with no parity error.
- s1 writes 0xDEADBEEF to address 5 with byteenable 4'b0101, then reads address 5 with READ_LATENCY=2 → 0x00AD00EF valid 2 cycles after accept.
- Same-cycle writes to address 9:
  - stimulus: s1 writes 0x11111111 with byteenable 4'b0011; s2 writes 0x22222222 with byteenable 4'b0110.
  - required: a later read returns 0x00221111.
- s1 writes 0xA5A5A5A5 to address 3 with inject_parity=1, then s2 reads address 3 → s2_parity_error pulses with readdatavalid and parity_error_sticky stays 1.
- Back-to-back reads of addresses 0..7 on both ports, with clken low for 3 mid-stream cycles → 16 valid pulses in order, none lost or duplicated.
- reset_n pulsed at clear address 30 → the clear restarts and waitrequest stays high for a further 64 cycles.
- Read of address 70 (DEPTH=64) → returns 0 with readdatavalid=1.
